// File: rtl/alu.sv
// Registered 32-bit ALU: eight operations selected by Control, latency 1.
// Define ALU_FLAGS_EN to build the Negative/Carry/Overflow flag registers.
module alu (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Control,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        Negative,
  output logic        Carry,
  output logic        Overflow
);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_e;

`ifdef ALU_FLAGS_EN
  localparam int SUM_W = 33;
`else
  localparam int SUM_W = 32;
`endif

  op_e              op;
  logic             is_sub;
  logic [31:0]      b_op;
  logic [SUM_W-1:0] sum;
  logic             ovf;
  logic [31:0]      result_d, result_q;
  logic             zero_d, zero_q;

  assign op = op_e'(Control);

  // SUB and SLT share the adder as A + ~B + 1; SLT derives its answer from
  // the sign of that difference corrected by signed overflow.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    result_d = '0;
    is_sub   = (op == OP_SUB) || (op == OP_SLT);
    b_op     = is_sub ? ~B : B;
    sum      = SUM_W'(A) + SUM_W'(b_op) + SUM_W'(is_sub);
    ovf      = (A[31] == b_op[31]) && (sum[31] != A[31]);
    case (op)
      OP_ADD,
      OP_SUB: result_d = sum[31:0];
      OP_AND: result_d = A & B;
      OP_OR:  result_d = A | B;
      OP_XOR: result_d = A ^ B;
      OP_SLT: result_d = {31'd0, sum[31] ^ ovf};
      OP_SLL: result_d = A << B[4:0];
      OP_SRL: result_d = A >> B[4:0];
      default: result_d = '0;
    endcase
    zero_d = (result_d == 32'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign Result = result_q;
  assign Zero   = zero_q;

`ifdef ALU_FLAGS_EN
  logic carry_d, ovf_d;
  logic neg_q, carry_q, ovf_q;

  always_comb begin
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        carry_d = sum[32];
        ovf_d   = ovf;
      end
      OP_SLT:  carry_d = sum[32];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      neg_q   <= result_d[31];
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Negative = neg_q;
  assign Carry    = carry_q;
  assign Overflow = ovf_q;
`else
  assign Negative = 1'b0;
  assign Carry    = 1'b0;
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: expected results are queued when inputs are driven
// and compared one edge later, when the registered outputs update.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] A, B;
  logic [2:0]  Control;
  logic [31:0] Result;
  logic        Zero, Negative, Carry, Overflow;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        neg;
    logic        carry;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp;
  int   n_tests = 0;
  int   n_fail  = 0;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .A        (A),
    .B        (B),
    .Control  (Control),
    .Result   (Result),
    .Zero     (Zero),
    .Negative (Negative),
    .Carry    (Carry),
    .Overflow (Overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [2:0] c);
    exp_t        e;
    longint      sa, sb, ls;
    logic [32:0] wide;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (c)
      3'd0: begin
        e.result = a + b;
        wide     = {1'b0, a} + {1'b0, b};
        e.carry  = wide[32];
        ls       = sa + sb;
        e.ovf    = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      3'd1: begin
        e.result = a - b;
        e.carry  = (a >= b);
        ls       = sa - sb;
        e.ovf    = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
      end
      3'd2: e.result = a & b;
      3'd3: e.result = a | b;
      3'd4: e.result = a ^ b;
      3'd5: begin
        e.result = (sa < sb) ? 32'd1 : 32'd0;
        e.carry  = (a >= b);
      end
      3'd6: e.result = a << b[4:0];
      default: e.result = a >> b[4:0];
    endcase
    e.zero = (e.result == 32'd0);
    e.neg  = e.result[31];
`ifndef ALU_FLAGS_EN
    e.neg   = 1'b0;
    e.carry = 1'b0;
    e.ovf   = 1'b0;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, ".result"},   Result,          e.result);
    check({tag, ".zero"},     {31'd0, Zero},     {31'd0, e.zero});
    check({tag, ".negative"}, {31'd0, Negative}, {31'd0, e.neg});
    check({tag, ".carry"},    {31'd0, Carry},    {31'd0, e.carry});
    check({tag, ".overflow"}, {31'd0, Overflow}, {31'd0, e.ovf});
  endtask

  task automatic check_outputs(input string tag);
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s: observed no queued expectation expected one", tag);
    end else begin
      last_exp = exp_q.pop_front();
      check_fields(tag, last_exp);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] c);
    A = a; B = b; Control = c;
    exp_q.push_back(model(a, b, c));
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  task automatic reset_step(input string tag);
    rst = 1'b1; A = 32'd5; B = 32'd3; Control = 3'b000;
    exp_q.push_back(exp_t'{result: 32'd0, zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0});
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    rst = 1'b1; A = '0; B = '0; Control = '0;
    #2;

    // Reset held two cycles with an ADD presented; it must be discarded.
    reset_step("rst0");
    reset_step("rst1");
    rst = 1'b0;
    step("first_add", 32'd5, 32'd3, 3'b000);

    // Arithmetic
    step("add_neg",    32'd12, -32'sd9, 3'b000);
    step("add_small",  32'd4,  32'd7,   3'b000);
    step("sub_eq",     32'd7,  32'd7,   3'b001);
    step("sub_borrow", 32'd3,  32'd10,  3'b001);
    step("sub_ovf",    32'h8000_0000, 32'd1, 3'b001);

    // Logic
    step("and", 32'd12, 32'd7, 3'b010);
    step("or",  32'd3,  32'd5, 3'b011);
    step("xor", 32'd3,  32'd5, 3'b100);

    // Shifts
    step("srl0_5",    32'd5,  32'd0, 3'b111);
    step("srl0_13",   32'd13, 32'd0, 3'b111);
    step("srl_b33",   32'h8000_0000, 32'h21, 3'b111);
    step("sll31",     32'd1,  32'd31, 3'b110);
    step("sll_hiB",   32'h0000_00F0, 32'hFFFF_FFE4, 3'b110);

    // Compare and overflow
    step("slt_m1_1",  32'hFFFF_FFFF, 32'd1, 3'b101);
    step("slt_1_m1",  32'd1, 32'hFFFF_FFFF, 3'b101);
    step("slt_ovf",   32'h8000_0000, 32'h7FFF_FFFF, 3'b101);
    step("add_ovf",   32'h7FFF_FFFF, 32'd1, 3'b000);

    // Inputs changing between edges must not disturb the held outputs.
    A = 32'hDEAD_BEEF; B = 32'd9; Control = 3'b100;
    #3;
    check_fields("hold", last_exp);

    // Back-to-back operations, one per cycle, each checked one edge later.
    step("pipe0", 32'd100,        32'd23,          3'b000);
    step("pipe1", 32'd100,        32'd23,          3'b001);
    step("pipe2", 32'hF0F0_F0F0,  32'h0FF0_0FF0,   3'b010);
    step("pipe3", 32'hF0F0_F0F0,  32'h0FF0_0FF0,   3'b011);
    step("pipe4", 32'hAAAA_5555,  32'hFFFF_0000,   3'b100);
    step("pipe5", 32'd2,          32'hFFFF_FFFE,   3'b101);
    step("pipe6", 32'h1234_5678,  32'd4,           3'b110);
    step("pipe7", 32'h1234_5678,  32'd8,           3'b111);

    // Reset mid-stream discards the presented operation.
    reset_step("rst_mid");
    rst = 1'b0;
    step("post_rst", 32'd0, 32'd0, 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
